// File: rtl/spi_disp_pkg.sv
// -----------------------------------------------------------------------------
// spi_disp_pkg
// Shared constants and types for the display-side SPI write-link receiver.
//   - command byte values understood by the decoder
//   - decoder state encoding and a command-to-state helper
//   - PIX_W: width of one RGB565 pixel word
// -----------------------------------------------------------------------------
package spi_disp_pkg;

  localparam int PIX_W = 16;

  localparam logic [7:0] CMD_SET_COLUMN = 8'h2A;
  localparam logic [7:0] CMD_SET_PAGE   = 8'h2B;
  localparam logic [7:0] CMD_WRITE_RAM  = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,  // data bytes ignored
    ST_COL,   // collecting 4 column-window parameters
    ST_PAGE,  // collecting 4 page-window parameters
    ST_RAM,   // pixel byte pairs stream into the window
    ST_SKIP   // unknown command, parameters discarded
  } dec_state_e;

  // Decoder state entered when a command byte arrives.
  function automatic dec_state_e cmd_to_state(input logic [7:0] cmd);
    case (cmd)
      CMD_SET_COLUMN: return ST_COL;
      CMD_SET_PAGE:   return ST_PAGE;
      CMD_WRITE_RAM:  return ST_RAM;
      default:        return ST_SKIP;
    endcase
  endfunction

endpackage

// File: rtl/spi_disp_rx_if.sv
// -----------------------------------------------------------------------------
// spi_disp_rx_if
// Bundles the 4-wire SPI write link and the decoded pixel/command outputs of
// spi_disp_rx.
//   slave  modport : the receiver (SPI wires in, pixel/command strobes out)
//   master modport : the link driver / framebuffer side (opposite directions)
// Signals:
//   i_sclk, i_mosi, i_dc, i_cs        SPI clock, data, data/command, chip select
//   o_pix_we, o_pix_x, o_pix_y,
//   o_pix_data                        addressed pixel write strobe
//   o_cmd_we, o_cmd                   command strobe and last command byte
//   o_err                             protocol error pulse
// -----------------------------------------------------------------------------
interface spi_disp_rx_if #(
  parameter int COORD_W = 9
);
  import spi_disp_pkg::*;

  logic               i_sclk;
  logic               i_mosi;
  logic               i_dc;
  logic               i_cs;
  logic               o_pix_we;
  logic [COORD_W-1:0] o_pix_x;
  logic [COORD_W-1:0] o_pix_y;
  logic [PIX_W-1:0]   o_pix_data;
  logic               o_cmd_we;
  logic [7:0]         o_cmd;
  logic               o_err;

  modport slave (
    input  i_sclk, i_mosi, i_dc, i_cs,
    output o_pix_we, o_pix_x, o_pix_y, o_pix_data, o_cmd_we, o_cmd, o_err
  );

  modport master (
    output i_sclk, i_mosi, i_dc, i_cs,
    input  o_pix_we, o_pix_x, o_pix_y, o_pix_data, o_cmd_we, o_cmd, o_err
  );

endinterface

// File: rtl/spi_rx_shift.sv
// -----------------------------------------------------------------------------
// spi_rx_shift
// Oversampling SPI byte assembler. Synchronises SCLK/MOSI/DC/CS into the
// system clock domain, detects SCLK rising edges and shifts bits in MSB-first.
// Ports:
//   i_clk, i_rst   system clock, synchronous active-high reset
//   sclk, mosi,
//   dc, cs         raw SPI link inputs (cs active low)
//   rx_byte        assembled byte, valid with byte_valid
//   rx_dc          DC level captured on the 8th SCLK rise
//   byte_valid     one-cycle pulse, the cycle after the 8th rise
//   partial_abort  one-cycle pulse when CS rises with a partial byte
// -----------------------------------------------------------------------------
module spi_rx_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       cs,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_valid,
  output logic       partial_abort
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] cs_sync;

  logic       sclk_s;
  logic       mosi_s;
  logic       dc_s;
  logic       cs_s;
  logic       sclk_d;
  logic       sclk_rise;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;

  // NOTE: the synchroniser flops are reset to 0 (CS seen low) on purpose so
  // a CS that is already low when reset releases cannot look like a fresh
  // CS-low; the receiver stays unarmed until a real CS high is observed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_d        <= 1'b0;
      armed         <= 1'b0;
      bit_cnt       <= 3'd0;
      shift_q       <= 7'd0;
      rx_byte       <= 8'd0;
      rx_dc         <= 1'b0;
      byte_valid    <= 1'b0;
      partial_abort <= 1'b0;
    end else begin
      sclk_d        <= sclk_s;
      byte_valid    <= 1'b0;
      partial_abort <= 1'b0;
      if (cs_s) begin
        // Deselected: drop any partial byte; bit_cnt is only non-zero mid-byte
        // so the abort pulse fires once per offending CS rise.
        armed         <= 1'b1;
        partial_abort <= (bit_cnt != 3'd0);
        bit_cnt       <= 3'd0;
        shift_q       <= 7'd0;
      end else if (armed && sclk_rise) begin
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {shift_q, mosi_s};
          rx_dc      <= dc_s;
          byte_valid <= 1'b1;
          bit_cnt    <= 3'd0;
          shift_q    <= 7'd0;
        end else begin
          shift_q <= {shift_q[5:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_disp_rx.sv
// -----------------------------------------------------------------------------
// spi_disp_rx
// Display-side SPI responder. Decodes SET_COLUMN / SET_PAGE / WRITE_RAM from
// the byte stream of spi_rx_shift and emits one addressed RGB565 pixel write
// per received byte pair, walking a cursor through the programmed window.
// Ports:
//   i_clk   system clock (>= 4x SCLK)
//   i_rst   synchronous active-high reset
//   bus     spi_disp_rx_if.slave: SPI link in, pixel/command/error strobes out
// Parameters:
//   SYNC_STAGES  synchroniser depth on the SPI inputs (>= 2)
//   COORD_W      pixel coordinate width; must match bus COORD_W
// Build option:
//   SPI_DISP_RX_PROTO_CHECK_EN  when defined, o_err pulses on protocol
//                               violations; otherwise o_err is tied low.
// -----------------------------------------------------------------------------
module spi_disp_rx
  import spi_disp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  spi_disp_rx_if.slave  bus
);

  logic [7:0]         rx_byte;
  logic               rx_dc;
  logic               byte_valid;
  logic               partial_abort;

  dec_state_e         state_q;
  dec_state_e         state_d;
  logic [1:0]         param_idx;
  logic [23:0]        param_buf;   // first three parameters, oldest in [23:16]
  logic               ram_phase;   // 1: high byte of a pixel is pending
  logic [7:0]         hi_byte;

  logic [COORD_W-1:0] sc, ec, sp, ep;
  logic [COORD_W-1:0] cur_x, cur_y;

  logic               pix_we;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [PIX_W-1:0]   pix_data;
  logic               cmd_we;
  logic [7:0]         cmd;
  logic               err;

  logic [PIX_W-1:0]   start_word;
  logic [PIX_W-1:0]   end_word;
  logic               last_param;
  logic               is_cmd;
  logic               is_data;

  spi_rx_shift #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shift (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .sclk          (bus.i_sclk),
    .mosi          (bus.i_mosi),
    .dc            (bus.i_dc),
    .cs            (bus.i_cs),
    .rx_byte       (rx_byte),
    .rx_dc         (rx_dc),
    .byte_valid    (byte_valid),
    .partial_abort (partial_abort)
  );

  assign is_cmd     = byte_valid & ~rx_dc;
  assign is_data    = byte_valid &  rx_dc;
  assign last_param = (param_idx == 2'd3);

  // Window bounds are the 16-bit protocol addresses; only the low COORD_W
  // bits are kept.
  assign start_word = param_buf[23:8];
  assign end_word   = {param_buf[7:0], rx_byte};

  generate
    if (COORD_W < PIX_W) begin : g_addr_trunc
      logic unused_addr_bits;
      assign unused_addr_bits = ^{start_word[PIX_W-1:COORD_W],
                                  end_word[PIX_W-1:COORD_W]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (is_cmd) begin
      // Commands redirect from any state, abandoning short parameter lists.
      state_d = cmd_to_state(rx_byte);
    end else if (is_data) begin
      if ((state_q == ST_COL || state_q == ST_PAGE) && last_param) begin
        state_d = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Parameters, window, cursor and output strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      param_idx <= 2'd0;
      param_buf <= 24'd0;
      ram_phase <= 1'b0;
      hi_byte   <= 8'd0;
      sc        <= '0;
      ec        <= '0;
      sp        <= '0;
      ep        <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      pix_we    <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      cmd_we    <= 1'b0;
      cmd       <= 8'd0;
    end else begin
      pix_we <= 1'b0;
      cmd_we <= 1'b0;
      if (is_cmd) begin
        cmd       <= rx_byte;
        cmd_we    <= 1'b1;
        param_idx <= 2'd0;
        param_buf <= 24'd0;
        ram_phase <= 1'b0;   // an odd trailing RAM byte is dropped here
        if (rx_byte == CMD_WRITE_RAM) begin
          cur_x <= sc;
          cur_y <= sp;
        end
      end else if (is_data) begin
        case (state_q)
          ST_COL, ST_PAGE: begin
            if (last_param) begin
              param_idx <= 2'd0;
              if (state_q == ST_COL) begin
                sc <= start_word[COORD_W-1:0];
                ec <= end_word[COORD_W-1:0];
              end else begin
                sp <= start_word[COORD_W-1:0];
                ep <= end_word[COORD_W-1:0];
              end
            end else begin
              param_buf <= {param_buf[15:0], rx_byte};
              param_idx <= param_idx + 2'd1;
            end
          end
          ST_RAM: begin
            if (!ram_phase) begin
              hi_byte   <= rx_byte;
              ram_phase <= 1'b1;
            end else begin
              ram_phase <= 1'b0;
              pix_we    <= 1'b1;
              pix_x     <= cur_x;
              pix_y     <= cur_y;
              pix_data  <= {hi_byte, rx_byte};
              // '>=' makes an inverted window (start > end) act as one line.
              if (cur_x >= ec) begin
                cur_x <= sc;
                cur_y <= (cur_y >= ep) ? sp : cur_y + 1'b1;
              end else begin
                cur_x <= cur_x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
`ifdef SPI_DISP_RX_PROTO_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err <= 1'b0;
    end else begin
      err <= partial_abort
           | (is_cmd  && (state_q == ST_COL || state_q == ST_PAGE))
           | (is_cmd  && state_q == ST_RAM && ram_phase)
           | (is_data && state_q == ST_IDLE);
    end
  end
`else
  logic unused_abort;
  assign unused_abort = partial_abort;
  assign err          = 1'b0;
`endif

  assign bus.o_pix_we   = pix_we;
  assign bus.o_pix_x    = pix_x;
  assign bus.o_pix_y    = pix_y;
  assign bus.o_pix_data = pix_data;
  assign bus.o_cmd_we   = cmd_we;
  assign bus.o_cmd      = cmd;
  assign bus.o_err      = err;

endmodule

// File: tb/tb_spi_disp_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_disp_rx
// Drives SPI transactions into spi_disp_rx. A protocol-level reference model
// predicts pixel writes, command strobes and error pulses; a monitor on the
// falling clock edge pops the predictions as the DUT produces its outputs.
// -----------------------------------------------------------------------------
module tb_spi_disp_rx;
  import spi_disp_pkg::*;

  localparam int COORD_W = 9;
  localparam int CMASK   = (1 << COORD_W) - 1;
`ifdef SPI_DISP_RX_PROTO_CHECK_EN
  localparam bit PROTO = 1'b1;
`else
  localparam bit PROTO = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  spi_disp_rx_if #(.COORD_W(COORD_W)) bus ();

  spi_disp_rx #(
    .SYNC_STAGES (2),
    .COORD_W     (COORD_W)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int data;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_cmd[$];
  int   txq[$];
  int   checks    = 0;
  int   failures  = 0;
  int   err_seen  = 0;
  int   err_exp   = 0;

  // ---------------- reference model (protocol level) ----------------
  localparam int M_IDLE = 0, M_COL = 1, M_PAGE = 2, M_RAM = 3, M_SKIP = 4;
  int m_mode;
  int m_params[$];
  int m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  bit m_pending;
  int m_hi;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_params.delete();
    m_sc = 0; m_ec = 0; m_sp = 0; m_ep = 0; m_x = 0; m_y = 0;
    m_pending = 1'b0;
    m_hi = 0;
  endtask

  task automatic model_cmd(input int b);
    exp_cmd.push_back(b);
    if (PROTO && (m_mode == M_COL || m_mode == M_PAGE)) err_exp++;
    if (PROTO && m_mode == M_RAM && m_pending) err_exp++;
    m_params.delete();
    m_pending = 1'b0;
    case (b)
      'h2A: m_mode = M_COL;
      'h2B: m_mode = M_PAGE;
      'h2C: begin m_mode = M_RAM; m_x = m_sc; m_y = m_sp; end
      default: m_mode = M_SKIP;
    endcase
  endtask

  task automatic model_data(input int b);
    int lo, hi;
    case (m_mode)
      M_IDLE: if (PROTO) err_exp++;
      M_COL, M_PAGE: begin
        m_params.push_back(b);
        if (m_params.size() == 4) begin
          lo = ((m_params[0] * 256) + m_params[1]) & CMASK;
          hi = ((m_params[2] * 256) + m_params[3]) & CMASK;
          if (m_mode == M_COL) begin m_sc = lo; m_ec = hi; end
          else                 begin m_sp = lo; m_ep = hi; end
          m_params.delete();
          m_mode = M_IDLE;
        end
      end
      M_RAM: begin
        if (!m_pending) begin
          m_hi = b;
          m_pending = 1'b1;
        end else begin
          exp_pix.push_back('{x: m_x, y: m_y, data: m_hi * 256 + b});
          m_pending = 1'b0;
          if (m_x >= m_ec) begin
            m_x = m_sc;
            m_y = (m_y >= m_ep) ? m_sp : ((m_y + 1) & CMASK);
          end else begin
            m_x = (m_x + 1) & CMASK;
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- SPI driver ----------------
  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    bus.i_dc = dc;
    for (int i = 0; i < n; i++) begin
      bus.i_mosi = b[7-i];
      #40 bus.i_sclk = 1'b1;
      #40 bus.i_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input int b);
    if (dc) model_data(b);
    else    model_cmd(b);
    spi_bits(dc, b[7:0], 8);
  endtask

  task automatic cs_low();
    bus.i_cs = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40 bus.i_cs = 1'b1;
    #80;
  endtask

  // One CS frame: txq[0] is a command when has_cmd is set, the rest are data.
  task automatic send_txn(input bit has_cmd);
    cs_low();
    foreach (txq[i]) send_byte((i == 0 && has_cmd) ? 1'b0 : 1'b1, txq[i]);
    cs_high();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_we"},   bus.o_pix_we,   0);
    check({tag, "_pix_x"},    bus.o_pix_x,    0);
    check({tag, "_pix_y"},    bus.o_pix_y,    0);
    check({tag, "_pix_data"}, bus.o_pix_data, 0);
    check({tag, "_cmd_we"},   bus.o_cmd_we,   0);
    check({tag, "_cmd"},      bus.o_cmd,      0);
    check({tag, "_err"},      bus.o_err,      0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (i_rst === 1'b0) begin
      if (bus.o_pix_we === 1'b1) begin
        if (exp_pix.size() == 0) begin
          check("pix_unexpected", 1, 0);
        end else begin
          pix_t p;
          p = exp_pix.pop_front();
          check("pix_x",    bus.o_pix_x,    p.x);
          check("pix_y",    bus.o_pix_y,    p.y);
          check("pix_data", bus.o_pix_data, p.data);
        end
      end
      if (bus.o_cmd_we === 1'b1) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected", 1, 0);
        else                     check("cmd", bus.o_cmd, exp_cmd.pop_front());
      end
      if (bus.o_err === 1'b1) err_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind, n;
    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_dc   = 1'b0;
    bus.i_cs   = 1'b1;
    i_rst      = 1'b1;
    model_reset();
    repeat (5) @(posedge i_clk);
    #1 check_reset_outputs("rst");
    @(negedge i_clk) i_rst = 1'b0;
    #100;

    // Window x 10..12, y 20; three white pixels.
    txq = '{'h2A, 'h00, 'h0A, 'h00, 'h0C}; send_txn(1);
    txq = '{'h2B, 'h00, 'h14, 'h00, 'h14}; send_txn(1);
    txq = '{'h2C, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'hFF}; send_txn(1);

    // Window 5..6 x 7..8; five pixels, the last wraps to the start.
    txq = '{'h2A, 'h00, 'h05, 'h00, 'h06}; send_txn(1);
    txq = '{'h2B, 'h00, 'h07, 'h00, 'h08}; send_txn(1);
    txq = '{'h2C, 'h00, 'h01, 'h00, 'h02, 'h00, 'h03, 'h00, 'h04, 'h00, 'h05};
    send_txn(1);

    // CS aborts a partial RAM byte; the following whole pair still lands.
    txq = '{'h2C}; send_txn(1);
    cs_low();
    spi_bits(1'b1, 8'hA5, 5);
    if (PROTO) err_exp++;
    cs_high();
    txq = '{'h00, 'h1F}; send_txn(0);

    // Short column sequence leaves the column window unchanged.
    txq = '{'h2A, 'h00, 'h03}; send_txn(1);
    txq = '{'h2B, 'h00, 'h01, 'h00, 'h01}; send_txn(1);
    txq = '{'h2C, 'h12, 'h34}; send_txn(1);

    // Unknown command's parameter is discarded.
    txq = '{'h36, 'h48}; send_txn(1);
    txq = '{'h2C, 'hAB, 'hCD}; send_txn(1);

    // Reset in the middle of a SET_PAGE parameter, CS still low afterwards.
    cs_low();
    send_byte(1'b0, 'h2B);
    send_byte(1'b1, 'h00);
    spi_bits(1'b1, 8'h5A, 3);
    @(negedge i_clk) i_rst = 1'b1;
    spi_bits(1'b1, 8'hFF, 3);
    @(negedge i_clk);
    check_reset_outputs("midrst");
    model_reset();
    i_rst = 1'b0;
    spi_bits(1'b1, 8'hC0, 2);
    cs_high();
    txq = '{'h2C, 'h11, 'h22, 'h33, 'h44}; send_txn(1);
    txq = '{'h2A, 'h00, 'h02, 'h00, 'h03}; send_txn(1);
    txq = '{'h2B, 'h00, 'h04, 'h00, 'h05}; send_txn(1);
    txq = '{'h2C, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06}; send_txn(1);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      txq.delete();
      if (kind <= 3) begin
        // Window command, usually complete, with occasional truncation.
        txq.push_back(kind[0] ? 'h2B : 'h2A);
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 4;
        for (int i = 0; i < n; i++)
          txq.push_back((i % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255));
        send_txn(1);
      end else if (kind <= 6) begin
        txq.push_back('h2C);
        n = $urandom_range(0, 9);
        for (int i = 0; i < n; i++) txq.push_back($urandom_range(0, 255));
        send_txn(1);
      end else if (kind == 7) begin
        txq.push_back($urandom_range(0, 255));
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) txq.push_back($urandom_range(0, 255));
        send_txn(1);
      end else if (kind == 8) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) txq.push_back($urandom_range(0, 255));
        send_txn(0);
      end else begin
        cs_low();
        spi_bits(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 7));
        if (PROTO) err_exp++;
        cs_high();
      end
    end

    #500;
    check("pix_queue_drained", exp_pix.size(), 0);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("err_pulse_count",   err_seen,       err_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
